multiplier_32fp: RTL and testbench
==================================

Name: multiplier_32fp

Overview:
- Multi-cycle IEEE-754 single-precision (binary32) floating-point multiplier with a start/done handshake.
- Computes product_o = a_i × b_i with round-to-nearest-even.
- Flags NaN, infinity, overflow and underflow results.
- Used as a datapath arithmetic unit driven by a controller or a test-vector sequencer.

Parameters:
- none (format fixed: 1 sign, 8 exponent, 23 fraction bits, bias 127)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- a_i  in  32  operand A, binary32
- b_i  in  32  operand B, binary32
- start_i  in  1  start request, sampled only in IDLE
- done_o  out  1  one-cycle pulse: result and flags valid
- nan_o  out  1  result is NaN
- inifinit_o  out  1  result is ±infinity (includes overflow)
- overflow_o  out  1  finite operands produced a magnitude above the max finite value
- underflow_o  out  1  nonzero exact result flushed to zero
- product_o  out  32  binary32 result

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, FSM = IDLE, internal registers 0. Reset mid-operation aborts the operation; no done_o follows.

FSM: IDLE -> MULT -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - On a clk edge with start_i=1, latch a_i and b_i, then go to MULT.
  - start_i is ignored in every other state, and operand changes after latching are ignored.
- MULT:
  - Classify operands (zero, subnormal, normal, inf, NaN).
  - sign = sa XOR sb.
  - exp_sum = ea + eb − 127, in a 10-bit signed register.
  - 48-bit mantissa product of {1, fa} × {1, fb}.
- NORM:
  - If product bit 47 = 1, shift right 1 and increment exponent.
  - Form a 24-bit mantissa plus guard bit and sticky bit (OR of the remaining low bits).
- ROUND:
  - RNE: increment if guard & (sticky | lsb).
  - On mantissa carry-out, shift and increment exponent.
  - Check range, pack, and register product_o and all flags.
- DONE:
  - done_o = 1 for exactly this one cycle, then go to IDLE.

Latency and output holding:
- The start-sampling edge is edge 1. done_o is high from edge 4 to edge 5, giving 4-cycle latency and a throughput of one operation per 5 cycles.
- product_o and the flags are updated only at the ROUND→DONE transition and hold until the next result or reset.
- In IDLE, a back-to-back start (start_i held high) is accepted on the edge after DONE.

Special cases, in priority order:
1. Either operand NaN, or zero × inf: product_o = 0x7FC00000 (sign 0), nan_o = 1, other flags 0.
2. Either operand inf (other nonzero): product_o = {sign, 0xFF, 0}, inifinit_o = 1.
3. Either operand zero: product_o = {sign, 31'b0}, all flags 0.
4. Subnormal inputs are flushed to signed zero and handled as case 3. No flag is raised for the flush.

Range rules after rounding, where E is the final biased exponent:
- E ≥ 255: product_o = {sign, 0xFF, 0}, overflow_o = 1, inifinit_o = 1.
- E ≤ 0: product_o = {sign, 31'b0}, underflow_o = 1. No subnormal outputs are produced.
- Otherwise: normal pack with all flags 0.

Flag rules:
- Flags are mutually consistent; only inifinit_o may accompany overflow_o.

Test Plan:
- 0x40400000 × 0x40000000 (3.0 × 2.0) -> product_o = 0x40C00000, done_o high exactly 4 cycles after start, all flags 0.
- 0x3FC00000 × 0xC0200000 (1.5 × −2.5) -> 0xC0700000. Then 0x3F800001 × 0x3F800001 -> 0x3F800002 (RNE with sticky).
- 0x7FC00000 × 0x3F800000 -> 0x7FC00000, nan_o = 1. 0x00000000 × 0x7F800000 -> 0x7FC00000, nan_o = 1. 0xFF800000 × 0x40000000 -> 0xFF800000, inifinit_o = 1.
- 0x7F000000 × 0x7F000000 -> 0x7F800000, overflow_o = 1, inifinit_o = 1. 0x00800000 × 0x00800000 -> 0x00000000, underflow_o = 1.
- 0x80000000 × 0x3F800000 -> 0x80000000, no flags. Subnormal 0x00000001 × 0x40000000 -> 0x00000000, no flags.
- Handshake/reset:
  - Pulse start_i during MULT -> ignored, single done_o.
  - Hold start_i high -> a done_o pulse every 5 cycles.
  - Assert rst_n=0 during NORM -> outputs 0 immediately (asynchronously), no done_o, next start works normally.

Source files
------------

// File: rtl/multiplier_32fp.sv
// Multi-cycle IEEE-754 binary32 multiplier with a start/done handshake.
// Round-to-nearest-even, subnormal inputs flushed to zero, no subnormal
// outputs. Flags NaN, infinity, overflow and underflow results.
module multiplier_32fp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        start_i,
  output logic        done_o,
  output logic        nan_o,
  output logic        inifinit_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic [31:0] product_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // latched operands
  logic [31:0] a_q, b_q;

  // pipeline of the single operation
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [47:0]       prod_q;
  logic [23:0]       mant_q;
  logic              guard_q;
  logic              sticky_q;
  logic              nan_case_q;
  logic              inf_case_q;
  logic              zero_case_q;

  // operand classification (exponent 0 covers zero and flushed subnormals)
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [9:0]  exp_sum;
  logic [47:0] mant_a, mant_b;

  // rounding / packing
  logic              round_up;
  logic [24:0]       mant_sum;
  logic [23:0]       mant_fin;
  logic signed [9:0] exp_fin;
  logic [31:0]       res_prod;
  logic              res_nan, res_inf, res_ovf, res_unf;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed sequence, start only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = MULT;
      MULT:    state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: done pulses for the single DONE cycle
  always_comb begin
    done_o = (state == DONE);
  end

  // Operand classification and exponent/mantissa preparation
  always_comb begin
    a_exp   = a_q[30:23];
    b_exp   = b_q[30:23];
    a_frac  = a_q[22:0];
    b_frac  = b_q[22:0];
    a_nan   = (a_exp == 8'hFF) && (a_frac != '0);
    b_nan   = (b_exp == 8'hFF) && (b_frac != '0);
    a_inf   = (a_exp == 8'hFF) && (a_frac == '0);
    b_inf   = (b_exp == 8'hFF) && (b_frac == '0);
    a_zero  = (a_exp == 8'h00);
    b_zero  = (b_exp == 8'h00);
    exp_sum = {2'b00, a_exp} + {2'b00, b_exp} - 10'd127;
    mant_a  = {24'd0, 1'b1, a_frac};
    mant_b  = {24'd0, 1'b1, b_frac};
  end

  // Rounding, range check and result selection in priority order
  always_comb begin
    round_up = guard_q & (sticky_q | mant_q[0]);
    mant_sum = {1'b0, mant_q} + {24'd0, round_up};
    if (mant_sum[24]) begin
      mant_fin = mant_sum[24:1];
      exp_fin  = exp_q + 10'sd1;
    end else begin
      mant_fin = mant_sum[23:0];
      exp_fin  = exp_q;
    end

    res_prod = '0;
    res_nan  = 1'b0;
    res_inf  = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (nan_case_q) begin
      res_prod = 32'h7FC0_0000;
      res_nan  = 1'b1;
    end else if (inf_case_q) begin
      res_prod = {sign_q, 8'hFF, 23'd0};
      res_inf  = 1'b1;
    end else if (zero_case_q) begin
      res_prod = {sign_q, 31'd0};
    end else if (exp_fin >= 10'sd255) begin
      res_prod = {sign_q, 8'hFF, 23'd0};
      res_inf  = 1'b1;
      res_ovf  = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      res_prod = {sign_q, 31'd0};
      res_unf  = 1'b1;
    end else begin
      res_prod = {sign_q, exp_fin[7:0], mant_fin[22:0]};
    end
  end

  // Datapath: one stage of work per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      prod_q      <= '0;
      mant_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      nan_case_q  <= 1'b0;
      inf_case_q  <= 1'b0;
      zero_case_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_q <= a_i;
            b_q <= b_i;
          end
        end
        MULT: begin
          sign_q      <= a_q[31] ^ b_q[31];
          exp_q       <= signed'(exp_sum);
          prod_q      <= mant_a * mant_b;
          nan_case_q  <= a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
          inf_case_q  <= a_inf | b_inf;
          zero_case_q <= a_zero | b_zero;
        end
        NORM: begin
          if (prod_q[47]) begin
            mant_q   <= prod_q[47:24];
            guard_q  <= prod_q[23];
            sticky_q <= |prod_q[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            mant_q   <= prod_q[46:23];
            guard_q  <= prod_q[22];
            sticky_q <= |prod_q[21:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded only on ROUND -> DONE, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_o   <= '0;
      nan_o       <= 1'b0;
      inifinit_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (state == ROUND) begin
      product_o   <= res_prod;
      nan_o       <= res_nan;
      inifinit_o  <= res_inf;
      overflow_o  <= res_ovf;
      underflow_o <= res_unf;
    end
  end

endmodule

// File: tb/tb_multiplier_32fp.sv
// Testbench for multiplier_32fp: table of vectors through a scoreboard,
// plus handshake and mid-operation reset sequences.
module tb_multiplier_32fp;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_i, b_i;
  logic        start_i;
  logic        done_o, nan_o, inifinit_o, overflow_o, underflow_o;
  logic [31:0] product_o;

  multiplier_32fp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a_i),
    .b_i         (b_i),
    .start_i     (start_i),
    .done_o      (done_o),
    .nan_o       (nan_o),
    .inifinit_o  (inifinit_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .product_o   (product_o)
  );

  // flags packed as {nan, inf, overflow, underflow}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  f;
    int unsigned cyc;
  } exp_t;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_NAN  = 4'b1000;
  localparam logic [3:0] F_INF  = 4'b0100;
  localparam logic [3:0] F_OVF  = 4'b0110;
  localparam logic [3:0] F_UNF  = 4'b0001;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  vec_t        vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compares each done_o pulse against the head of the scoreboard
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check32("product", product_o, e.p);
          check32("flags", {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, {28'd0, e.f});
          check32("done_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [3:0] f);
    @(negedge clk);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    sb.push_back('{p: p, f: f, cyc: cyc + 4});
    @(negedge clk);
    start_i = 1'b0;
    wait_idle(20);
  endtask

  initial begin
    vecs.push_back('{a: 32'h40400000, b: 32'h40000000, p: 32'h40C00000, f: F_NONE});
    vecs.push_back('{a: 32'h3FC00000, b: 32'hC0200000, p: 32'hC0700000, f: F_NONE});
    vecs.push_back('{a: 32'h3F800001, b: 32'h3F800001, p: 32'h3F800002, f: F_NONE});
    vecs.push_back('{a: 32'h7FC00000, b: 32'h3F800000, p: 32'h7FC00000, f: F_NAN });
    vecs.push_back('{a: 32'h00000000, b: 32'h7F800000, p: 32'h7FC00000, f: F_NAN });
    vecs.push_back('{a: 32'hFF800000, b: 32'h40000000, p: 32'hFF800000, f: F_INF });
    vecs.push_back('{a: 32'h7F000000, b: 32'h7F000000, p: 32'h7F800000, f: F_OVF });
    vecs.push_back('{a: 32'h00800000, b: 32'h00800000, p: 32'h00000000, f: F_UNF });
    vecs.push_back('{a: 32'h80000000, b: 32'h3F800000, p: 32'h80000000, f: F_NONE});
    vecs.push_back('{a: 32'h00000001, b: 32'h40000000, p: 32'h00000000, f: F_NONE});
    vecs.push_back('{a: 32'h3F800000, b: 32'h3F800000, p: 32'h3F800000, f: F_NONE});
    vecs.push_back('{a: 32'h3F800001, b: 32'h3FC00000, p: 32'h3FC00002, f: F_NONE}); // tie, odd -> up
    vecs.push_back('{a: 32'h3F800003, b: 32'h3FC00000, p: 32'h3FC00004, f: F_NONE}); // tie, even -> stay
    vecs.push_back('{a: 32'h3F800001, b: 32'h3FFFFFFE, p: 32'h40000000, f: F_NONE}); // rounding carry-out
    vecs.push_back('{a: 32'h7F7FFFFF, b: 32'h3F800000, p: 32'h7F7FFFFF, f: F_NONE}); // max finite
    vecs.push_back('{a: 32'h7F7FFFFF, b: 32'h3F800001, p: 32'h7F800000, f: F_OVF });
    vecs.push_back('{a: 32'h00800000, b: 32'h3F800000, p: 32'h00800000, f: F_NONE}); // min normal
    vecs.push_back('{a: 32'h00800000, b: 32'h3F000000, p: 32'h00000000, f: F_UNF });
    vecs.push_back('{a: 32'hC0000000, b: 32'hC0400000, p: 32'h40C00000, f: F_NONE});
    vecs.push_back('{a: 32'h7F800000, b: 32'hFF800000, p: 32'hFF800000, f: F_INF });
    vecs.push_back('{a: 32'hFF800000, b: 32'h80000000, p: 32'h7FC00000, f: F_NAN });
    vecs.push_back('{a: 32'h80000000, b: 32'hC0000000, p: 32'h00000000, f: F_NONE});

    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    #3;
    check32("reset_product", product_o, 32'h0);
    check32("reset_flags", {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, 32'h0);
    check32("reset_done", {31'd0, done_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fork
      monitor();
    join_none

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].f);

    // start pulsed again during MULT with new operands: must be ignored
    @(negedge clk);
    a_i     = 32'h3FC00000;
    b_i     = 32'hC0200000;
    start_i = 1'b1;
    sb.push_back('{p: 32'hC0700000, f: F_NONE, cyc: cyc + 4});
    @(negedge clk);
    a_i     = 32'h40400000;
    b_i     = 32'h40000000;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle(20);
    repeat (8) @(negedge clk);

    // start held high: one result every 5 cycles
    @(negedge clk);
    a_i     = 32'h40400000;
    b_i     = 32'h40000000;
    start_i = 1'b1;
    for (int unsigned k = 0; k < 3; k++)
      sb.push_back('{p: 32'h40C00000, f: F_NONE, cyc: cyc + 4 + 5 * k});
    repeat (12) @(posedge clk);
    #1 start_i = 1'b0;
    wait_idle(20);
    repeat (6) @(negedge clk);

    // reset during NORM: outputs clear at once, no done follows
    @(negedge clk);
    a_i     = 32'h3FC00000;
    b_i     = 32'h40000000;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("async_reset_product", product_o, 32'h0);
    check32("async_reset_flags", {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, 32'h0);
    check32("async_reset_done", {31'd0, done_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, F_NONE);

    check32("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
